// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Recovers a six-digit clock frame (hh:mm:ss) from a multiplexed, active-low
// seven-segment display scan. Inputs pass through a capture stage (S1) and a
// pipeline copy of it (S2). The stability filter compares S1 with the previous
// S1 value and flags a slot exactly once when it has been steady STABLE times.
// Accepted slots feed an ordering FSM that stages the digits and commits a
// complete frame to the outputs in one edge.

module seg_scan_decoder #(
   parameter int STABLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seg7,
   input  logic [7:0] number,
   output logic [3:0] sec0,
   output logic [3:0] sec1,
   output logic [3:0] min0,
   output logic [3:0] min1,
   output logic [3:0] hour0,
   output logic [3:0] hour1,
   output logic       valid,
   output logic       frame_done,
   output logic       seq_err,
   output logic       sel_err,
   output logic       bad_digit
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } state_t;

   localparam logic [3:0] STABLE_L   = 4'(STABLE);
   localparam logic [2:0] SLOT_LAST  = 3'd5;
   localparam logic [2:0] SLOT_BLANK = 3'd6;
   localparam logic [2:0] SLOT_ILLEG = 3'd7;

   // Map an active-low segment pattern to its BCD digit; 4'hF when unknown.
   function automatic logic [3:0] decode_digit(input logic [7:0] num);
      logic [6:0] seg_on;
      logic [3:0] dig;
      seg_on = ~num[6:0];
      dig    = 4'hF;
      if (num[7] == 1'b0) begin
         dig = 4'hF;
      end else begin
         case (seg_on)
            7'h3F:   dig = 4'h0;
            7'h06:   dig = 4'h1;
            7'h5B:   dig = 4'h2;
            7'h4F:   dig = 4'h3;
            7'h66:   dig = 4'h4;
            7'h6D:   dig = 4'h5;
            7'h7D:   dig = 4'h6;
            7'h27:   dig = 4'h7;
            7'h7F:   dig = 4'h8;
            7'h67:   dig = 4'h9;
            default: dig = 4'hF;
         endcase
      end
      return dig;
   endfunction

   // Map an active-low digit select to slot 0..5, blank or illegal.
   function automatic logic [2:0] decode_slot(input logic [7:0] sel);
      logic [2:0] slot;
      case (sel)
         8'hFE:   slot = 3'd0;
         8'hFD:   slot = 3'd1;
         8'hF7:   slot = 3'd2;
         8'hEF:   slot = 3'd3;
         8'hBF:   slot = 3'd4;
         8'h7F:   slot = 3'd5;
         8'hFF:   slot = SLOT_BLANK;
         default: slot = SLOT_ILLEG;
      endcase
      return slot;
   endfunction

   logic [7:0] s1_seg7_r;
   logic [7:0] s1_number_r;
   logic [7:0] s2_seg7_r;
   logic [7:0] s2_number_r;
   logic [3:0] stab_cnt_r;
   logic [3:0] stab_nxt_s;
   logic       same_s;
   logic       hit_r;
   logic       hit_nxt_s;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [2:0] expect_r;
   logic [2:0] expect_nxt_s;
   logic [3:0] stage_r [0:5];

   logic [2:0] slot_s;
   logic [3:0] digit_s;
   logic       st_we_s;
   logic       st_clr_s;
   logic       commit_s;
   logic       seq_err_s;
   logic       sel_err_s;
   logic       bad_s;

   // Capture the raw scan inputs and keep one older copy for the stability compare.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_seg7_r   <= 8'hFF;
         s1_number_r <= 8'hFF;
         s2_seg7_r   <= 8'hFF;
         s2_number_r <= 8'hFF;
      end else begin
         s1_seg7_r   <= seg7;
         s1_number_r <= number;
         s2_seg7_r   <= s1_seg7_r;
         s2_number_r <= s1_number_r;
      end
   end

   // Next stability count (saturating) and the one-shot acceptance flag.
   always_comb begin
      same_s     = ({s1_seg7_r, s1_number_r} == {s2_seg7_r, s2_number_r});
      stab_nxt_s = 4'd1;
      if (!same_s) begin
         stab_nxt_s = 4'd1;
      end else if (stab_cnt_r >= STABLE_L) begin
         stab_nxt_s = STABLE_L;
      end else begin
         stab_nxt_s = stab_cnt_r + 4'd1;
      end
      hit_nxt_s = (stab_nxt_s == STABLE_L) && !(same_s && (stab_cnt_r == STABLE_L));
   end

   // Stability counter and acceptance flag registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stab_cnt_r <= 4'd0;
         hit_r      <= 1'b0;
      end else begin
         stab_cnt_r <= stab_nxt_s;
         hit_r      <= hit_nxt_s;
      end
   end

   assign slot_s  = decode_slot(s2_seg7_r);
   assign digit_s = decode_digit(s2_number_r);

   // Slot ordering: decide staging writes, errors and commit for an accepted slot.
   always_comb begin
      state_nxt_s  = state_r;
      expect_nxt_s = expect_r;
      st_we_s      = 1'b0;
      st_clr_s     = 1'b0;
      commit_s     = 1'b0;
      seq_err_s    = 1'b0;
      sel_err_s    = 1'b0;
      if (hit_r) begin
         case (slot_s)
            SLOT_BLANK: begin
               state_nxt_s = state_r;
            end
            SLOT_ILLEG: begin
               sel_err_s    = 1'b1;
               st_clr_s     = 1'b1;
               state_nxt_s  = IDLE;
               expect_nxt_s = 3'd0;
            end
            default: begin
               case (state_r)
                  IDLE: begin
                     if (slot_s == 3'd0) begin
                        st_we_s      = 1'b1;
                        expect_nxt_s = 3'd1;
                        state_nxt_s  = CAPTURE;
                     end else begin
                        state_nxt_s  = IDLE;
                     end
                  end
                  CAPTURE: begin
                     if (slot_s == expect_r) begin
                        st_we_s = 1'b1;
                        if (slot_s == SLOT_LAST) begin
                           commit_s     = 1'b1;
                           expect_nxt_s = 3'd0;
                           state_nxt_s  = IDLE;
                        end else begin
                           expect_nxt_s = expect_r + 3'd1;
                        end
                     end else begin
                        seq_err_s = 1'b1;
                        st_clr_s  = 1'b1;
                        if (slot_s == 3'd0) begin
                           st_we_s      = 1'b1;
                           expect_nxt_s = 3'd1;
                           state_nxt_s  = CAPTURE;
                        end else begin
                           expect_nxt_s = 3'd0;
                           state_nxt_s  = IDLE;
                        end
                     end
                  end
                  default: begin
                     expect_nxt_s = 3'd0;
                     state_nxt_s  = IDLE;
                  end
               endcase
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // FSM state, expected-slot counter and digit staging.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= IDLE;
         expect_r <= 3'd0;
         for (int i = 0; i < 6; i++) begin
            stage_r[i] <= 4'h0;
         end
      end else begin
         state_r  <= state_nxt_s;
         expect_r <= expect_nxt_s;
         for (int i = 0; i < 6; i++) begin
            if (st_we_s && (slot_s == 3'(i))) begin
               stage_r[i] <= digit_s;
            end else if (st_clr_s) begin
               stage_r[i] <= 4'h0;
            end
         end
      end
   end

   // Any undecodable digit in the frame being committed (hour0 arrives live).
   assign bad_s = (stage_r[0] == 4'hF) | (stage_r[1] == 4'hF) | (stage_r[2] == 4'hF) |
                  (stage_r[3] == 4'hF) | (stage_r[4] == 4'hF) | (digit_s == 4'hF);

   // Registered frame outputs and status pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sec0       <= 4'h0;
         sec1       <= 4'h0;
         min0       <= 4'h0;
         min1       <= 4'h0;
         hour0      <= 4'h0;
         hour1      <= 4'h0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
         seq_err    <= 1'b0;
         sel_err    <= 1'b0;
         bad_digit  <= 1'b0;
      end else begin
         frame_done <= commit_s;
         seq_err    <= seq_err_s;
         sel_err    <= sel_err_s;
         if (commit_s) begin
            sec1      <= stage_r[0];
            sec0      <= stage_r[1];
            min1      <= stage_r[2];
            min0      <= stage_r[3];
            hour1     <= stage_r[4];
            hour0     <= digit_s;
            valid     <= 1'b1;
            bad_digit <= bad_s;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: one instance with STABLE=1 and one
// with STABLE=3 share the same scan inputs.

module tb_seg_scan_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] seg7 = 8'hFF;
   logic [7:0] number = 8'hFF;

   logic [3:0] a_sec0, a_sec1, a_min0, a_min1, a_hour0, a_hour1;
   logic       a_valid, a_fd, a_seq, a_sel, a_bad;
   logic [3:0] b_sec0, b_sec1, b_min0, b_min1, b_hour0, b_hour1;
   logic       b_valid, b_fd, b_seq, b_sel, b_bad;

   logic [23:0] o1, o3;
   assign o1 = {a_hour1, a_hour0, a_min1, a_min0, a_sec1, a_sec0};
   assign o3 = {b_hour1, b_hour0, b_min1, b_min0, b_sec1, b_sec0};

   int errors = 0;
   int checks = 0;
   int fd1_cnt = 0, fd3_cnt = 0, seq1_cnt = 0, seq3_cnt = 0, sel1_cnt = 0;

   seg_scan_decoder #(.STABLE(1)) dut1 (
      .clk(clk), .rst(rst), .seg7(seg7), .number(number),
      .sec0(a_sec0), .sec1(a_sec1), .min0(a_min0), .min1(a_min1),
      .hour0(a_hour0), .hour1(a_hour1), .valid(a_valid), .frame_done(a_fd),
      .seq_err(a_seq), .sel_err(a_sel), .bad_digit(a_bad)
   );

   seg_scan_decoder #(.STABLE(3)) dut3 (
      .clk(clk), .rst(rst), .seg7(seg7), .number(number),
      .sec0(b_sec0), .sec1(b_sec1), .min0(b_min0), .min1(b_min1),
      .hour0(b_hour0), .hour1(b_hour1), .valid(b_valid), .frame_done(b_fd),
      .seq_err(b_seq), .sel_err(b_sel), .bad_digit(b_bad)
   );

   always #5 clk = ~clk;

   // Count status pulses away from the active edge.
   always @(negedge clk) begin
      if (a_fd)  fd1_cnt++;
      if (b_fd)  fd3_cnt++;
      if (a_seq) seq1_cnt++;
      if (b_seq) seq3_cnt++;
      if (a_sel) sel1_cnt++;
   end

   function automatic logic [7:0] sel_of(input int s);
      case (s)
         0: return 8'hFE;
         1: return 8'hFD;
         2: return 8'hF7;
         3: return 8'hEF;
         4: return 8'hBF;
         5: return 8'h7F;
         default: return 8'hFF;
      endcase
   endfunction

   // Classic active-low 7-segment codes with the blank bit high.
   function automatic logic [7:0] pat_of(input logic [3:0] d);
      case (d)
         4'h0: return 8'hC0;
         4'h1: return 8'hF9;
         4'h2: return 8'hA4;
         4'h3: return 8'hB0;
         4'h4: return 8'h99;
         4'h5: return 8'h92;
         4'h6: return 8'h82;
         4'h7: return 8'hD8;
         4'h8: return 8'h80;
         4'h9: return 8'h98;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic drive(input logic [7:0] s, input logic [7:0] n);
      @(negedge clk);
      seg7   = s;
      number = n;
   endtask

   task automatic blanks(input int k);
      for (int i = 0; i < k; i++) drive(8'hFF, 8'hFF);
   endtask

   // digs[4*i+:4] is the digit shown in slot i; each slot held 'hold' cycles.
   task automatic send_frame(input logic [23:0] digs, input int hold);
      for (int s = 0; s < 6; s++)
         for (int h = 0; h < hold; h++)
            drive(sel_of(s), pat_of(digs[4*s +: 4]));
   endtask

   task automatic test_reset;
      rst = 1'b0;
      blanks(2);
      checks++; if (o1 !== 24'h000000) begin errors++; $display("FAIL reset_digits got %h exp 000000", o1); end
      checks++; if ({a_valid, a_fd, a_seq, a_sel, a_bad} !== 5'b00000) begin errors++; $display("FAIL reset_flags got %b exp 00000", {a_valid, a_fd, a_seq, a_sel, a_bad}); end
      checks++; if ({b_valid, b_fd, b_bad} !== 3'b000) begin errors++; $display("FAIL reset_flags3 got %b exp 000", {b_valid, b_fd, b_bad}); end
      rst = 1'b1;
      blanks(2);
   endtask

   task automatic test_frame;
      send_frame(24'h214365, 1);
      drive(8'hFF, 8'hFF);
      drive(8'hFF, 8'hFF);
      checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL frame_early got %b exp 0", a_fd); end
      drive(8'hFF, 8'hFF);
      checks++; if (a_fd !== 1'b1) begin errors++; $display("FAIL frame_latency got %b exp 1", a_fd); end
      checks++; if (o1 !== 24'h123456) begin errors++; $display("FAIL frame_digits got %h exp 123456", o1); end
      checks++; if ({a_valid, a_bad} !== 2'b10) begin errors++; $display("FAIL frame_valid_bad got %b exp 10", {a_valid, a_bad}); end
      drive(8'hFF, 8'hFF);
      checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL frame_pulse_width got %b exp 0", a_fd); end
   endtask

   task automatic test_seq_err;
      int f0, q0;
      f0 = fd1_cnt; q0 = seq1_cnt;
      drive(sel_of(0), pat_of(4'h7));
      drive(sel_of(1), pat_of(4'h7));
      drive(sel_of(3), pat_of(4'h7));
      blanks(4);
      checks++; if (seq1_cnt !== q0 + 1) begin errors++; $display("FAIL seq_pulse got %0d exp %0d", seq1_cnt, q0 + 1); end
      checks++; if (fd1_cnt !== f0) begin errors++; $display("FAIL seq_no_commit got %0d exp %0d", fd1_cnt, f0); end
      checks++; if (o1 !== 24'h123456) begin errors++; $display("FAIL seq_hold got %h exp 123456", o1); end
   endtask

   task automatic test_sel_err;
      int f0, q0, s0;
      f0 = fd1_cnt; q0 = seq1_cnt; s0 = sel1_cnt;
      drive(sel_of(0), pat_of(4'h1));
      drive(sel_of(1), pat_of(4'h2));
      drive(8'hFC, pat_of(4'h3));
      blanks(4);
      checks++; if (sel1_cnt !== s0 + 1) begin errors++; $display("FAIL sel_pulse got %0d exp %0d", sel1_cnt, s0 + 1); end
      checks++; if (seq1_cnt !== q0) begin errors++; $display("FAIL sel_no_seq got %0d exp %0d", seq1_cnt, q0); end
      checks++; if (o1 !== 24'h123456) begin errors++; $display("FAIL sel_hold got %h exp 123456", o1); end
      send_frame(24'h456789, 1);
      blanks(4);
      checks++; if (fd1_cnt !== f0 + 1) begin errors++; $display("FAIL sel_next_commit got %0d exp %0d", fd1_cnt, f0 + 1); end
      checks++; if (o1 !== 24'h547698) begin errors++; $display("FAIL sel_next_digits got %h exp 547698", o1); end
   endtask

   task automatic test_bad_digit;
      send_frame(24'h00F321, 1);
      blanks(4);
      checks++; if (o1 !== 24'h003F12) begin errors++; $display("FAIL bad_digits got %h exp 003F12", o1); end
      checks++; if (a_bad !== 1'b1) begin errors++; $display("FAIL bad_flag got %b exp 1", a_bad); end
      send_frame(24'h900000, 1);
      blanks(4);
      checks++; if (o1 !== 24'h090000) begin errors++; $display("FAIL bad_clean_digits got %h exp 090000", o1); end
      checks++; if (a_bad !== 1'b0) begin errors++; $display("FAIL bad_clear got %b exp 0", a_bad); end
   endtask

   task automatic test_stable;
      int f3, q3, q1, f1;
      drive(8'hFF, 8'hFF);
      rst = 1'b0;
      blanks(2);
      rst = 1'b1;
      blanks(2);
      f3 = fd3_cnt; q3 = seq3_cnt;
      send_frame(24'h214365, 2);
      blanks(6);
      checks++; if (fd3_cnt !== f3) begin errors++; $display("FAIL stable_short_commit got %0d exp %0d", fd3_cnt, f3); end
      checks++; if ({b_valid, o3} !== {1'b0, 24'h000000}) begin errors++; $display("FAIL stable_short_out got %h exp 0000000", {b_valid, o3}); end
      send_frame(24'h214365, 3);
      blanks(6);
      checks++; if (fd3_cnt !== f3 + 1) begin errors++; $display("FAIL stable_commit got %0d exp %0d", fd3_cnt, f3 + 1); end
      checks++; if (o3 !== 24'h123456) begin errors++; $display("FAIL stable_digits got %h exp 123456", o3); end
      checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL stable_valid got %b exp 1", b_valid); end
      q1 = seq1_cnt; f1 = fd1_cnt;
      send_frame(24'h900000, 5);
      blanks(6);
      checks++; if (fd3_cnt !== f3 + 2) begin errors++; $display("FAIL stable_long_commit got %0d exp %0d", fd3_cnt, f3 + 2); end
      checks++; if (seq3_cnt !== q3) begin errors++; $display("FAIL stable_no_reaccept3 got %0d exp %0d", seq3_cnt, q3); end
      checks++; if (o3 !== 24'h090000) begin errors++; $display("FAIL stable_long_digits got %h exp 090000", o3); end
      checks++; if (seq1_cnt !== q1) begin errors++; $display("FAIL stable_no_reaccept1 got %0d exp %0d", seq1_cnt, q1); end
      checks++; if (fd1_cnt !== f1 + 1) begin errors++; $display("FAIL stable_long_commit1 got %0d exp %0d", fd1_cnt, f1 + 1); end
   endtask

   task automatic test_reset_midframe;
      int f0;
      checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", a_valid); end
      for (int s = 0; s < 4; s++) drive(sel_of(s), pat_of(4'h8));
      drive(8'hFF, 8'hFF);
      rst = 1'b0;
      drive(8'hFF, 8'hFF);
      rst = 1'b1;
      checks++; if (o1 !== 24'h000000) begin errors++; $display("FAIL mid_digits got %h exp 000000", o1); end
      checks++; if ({a_valid, a_fd, a_seq, a_sel, a_bad} !== 5'b00000) begin errors++; $display("FAIL mid_flags got %b exp 00000", {a_valid, a_fd, a_seq, a_sel, a_bad}); end
      f0 = fd1_cnt;
      drive(sel_of(4), pat_of(4'h8));
      drive(sel_of(5), pat_of(4'h8));
      blanks(4);
      checks++; if ({fd1_cnt, a_valid} !== {f0, 1'b0}) begin errors++; $display("FAIL mid_no_resume got %0d/%b exp %0d/0", fd1_cnt, a_valid, f0); end
      send_frame(24'h214365, 1);
      blanks(4);
      checks++; if (fd1_cnt !== f0 + 1) begin errors++; $display("FAIL mid_commit got %0d exp %0d", fd1_cnt, f0 + 1); end
      checks++; if ({a_valid, o1} !== {1'b1, 24'h123456}) begin errors++; $display("FAIL mid_digits_after got %h exp 1123456", {a_valid, o1}); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_seq_err();
      test_sel_err();
      test_bad_digit();
      test_stable();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
